// File: rtl/hazard_unit_mc_if.sv
// Pipeline-control bundle between the MIPS datapath (master) and the hazard unit (slave).
// Carries ID/EX match operands, control-transfer requests, and the resulting enables/flushes.
interface hazard_unit_mc_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  mem_read_IDEX_i;
    logic                  mem_write_IFID_i;
    logic                  uses_rs_IFID_i;
    logic                  uses_rt_IFID_i;
    logic [REG_ADDR_W-1:0] reg_rt_IDEX_i;
    logic [REG_ADDR_W-1:0] reg_rs_IFID_i;
    logic [REG_ADDR_W-1:0] reg_rt_IFID_i;
    logic                  jmp_i;
    logic                  jr_i;
    logic                  branch_taken_i;
    logic                  mem_busy_i;
    logic                  clear_cnt_i;
    logic                  PC_write_o;
    logic                  IFID_write_o;
    logic                  IDEX_write_o;
    logic                  ctl_flush_o;
    logic                  IFID_flush_o;
    logic                  IDEX_flush_o;
    logic                  mem_cpy_o;
    logic                  stall_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output mem_read_IDEX_i, mem_write_IFID_i, uses_rs_IFID_i, uses_rt_IFID_i,
               reg_rt_IDEX_i, reg_rs_IFID_i, reg_rt_IFID_i, jmp_i, jr_i,
               branch_taken_i, mem_busy_i, clear_cnt_i,
        input  PC_write_o, IFID_write_o, IDEX_write_o, ctl_flush_o, IFID_flush_o,
               IDEX_flush_o, mem_cpy_o, stall_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  mem_read_IDEX_i, mem_write_IFID_i, uses_rs_IFID_i, uses_rt_IFID_i,
               reg_rt_IDEX_i, reg_rs_IFID_i, reg_rt_IFID_i, jmp_i, jr_i,
               branch_taken_i, mem_busy_i, clear_cnt_i,
        output PC_write_o, IFID_write_o, IDEX_write_o, ctl_flush_o, IFID_flush_o,
               IDEX_flush_o, mem_cpy_o, stall_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard detection / pipeline control for the 5-stage MIPS pipeline: multi-cycle load-use
// stalls, lw->sw data copy, memory-busy freeze, jump/branch flushes and perf counters.
module hazard_unit_mc #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int EN_MEM_CPY        = 1,
    parameter int CNT_W             = 16
) (
    input logic            clk,
    input logic            reset,
    hazard_unit_mc_if.slave hz
);
    localparam int REM_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) + 1 : 1;
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t           state_reg, state_next;
    logic [REM_W-1:0] remaining_reg, remaining_next;

    logic rt_idex_nz, rs_hit, rt_hit, lu, cpy;
    logic pc_write, ifid_write, idex_write, ctl_flush, ifid_flush, idex_flush;
    logic mem_cpy, stall;

    // $zero is never a real load destination, so it can never create a dependency.
    assign rt_idex_nz = (hz.reg_rt_IDEX_i != '0);
    assign rs_hit     = hz.uses_rs_IFID_i && rt_idex_nz && (hz.reg_rs_IFID_i == hz.reg_rt_IDEX_i);
    assign rt_hit     = hz.uses_rt_IFID_i && rt_idex_nz && (hz.reg_rt_IFID_i == hz.reg_rt_IDEX_i);
    assign lu         = hz.mem_read_IDEX_i && (rs_hit || rt_hit);
    // Only store data may be copied; a dependent store address still needs the stall.
    assign cpy        = (EN_MEM_CPY != 0) && hz.mem_write_IFID_i && rt_hit && !rs_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        idex_write     = 1'b1;
        ctl_flush      = 1'b1;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        mem_cpy        = 1'b0;
        stall          = 1'b0;

        if (hz.mem_busy_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (state_reg == LU_STALL) begin
            stall          = 1'b1;
            remaining_next = remaining_reg - 1'b1;
            if (remaining_reg == REM_W'(1))
                state_next = RUN;
        end else if (lu && !cpy) begin
            stall = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_next     = LU_STALL;
                remaining_next = REM_LOAD;
            end
        end else begin
            mem_cpy = lu && cpy;
            if (hz.jmp_i || hz.jr_i) begin
                ifid_flush = 1'b0;
                idex_flush = 1'b0;
            end
            if (hz.branch_taken_i)
                ifid_flush = 1'b0;
        end

        // A stall holds PC and IF/ID and pushes a control-zeroed bubble into EX.
        if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctl_flush  = 1'b0;
        end
    end

    assign hz.PC_write_o   = pc_write;
    assign hz.IFID_write_o = ifid_write;
    assign hz.IDEX_write_o = idex_write;
    assign hz.ctl_flush_o  = ctl_flush;
    assign hz.IFID_flush_o = ifid_flush;
    assign hz.IDEX_flush_o = idex_flush;
    assign hz.mem_cpy_o    = mem_cpy;
    assign hz.stall_o      = stall;

    // Counter 0 tracks stall cycles, counter 1 tracks IF/ID flush cycles.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = stall;
    assign cnt_inc[1] = !ifid_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    cnt_reg <= '0;
                else if (hz.clear_cnt_i)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != CNT_MAX))
                    cnt_reg <= cnt_reg + 1'b1;
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign hz.stall_cnt_o = cnt_val[0];
    assign hz.flush_cnt_o = cnt_val[1];
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: three instances cover single-bubble, 3-cycle stall and
// 2-bit saturating counter configurations; every check is an immediate assertion.
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_ADDR_W(5), .CNT_W(16)) ia ();
    hazard_unit_mc_if #(.REG_ADDR_W(5), .CNT_W(16)) ib ();
    hazard_unit_mc_if #(.REG_ADDR_W(5), .CNT_W(2))  ic ();

    hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .EN_MEM_CPY(1), .CNT_W(16))
        u_a (.clk(clk), .reset(reset), .hz(ia));
    hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .EN_MEM_CPY(1), .CNT_W(16))
        u_b (.clk(clk), .reset(reset), .hz(ib));
    hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .EN_MEM_CPY(1), .CNT_W(2))
        u_c (.clk(clk), .reset(reset), .hz(ic));

    `define IDLE(x) begin \
        x.mem_read_IDEX_i = 1'b0; x.mem_write_IFID_i = 1'b0; \
        x.uses_rs_IFID_i = 1'b0; x.uses_rt_IFID_i = 1'b0; \
        x.reg_rt_IDEX_i = 5'd0; x.reg_rs_IFID_i = 5'd0; x.reg_rt_IFID_i = 5'd0; \
        x.jmp_i = 1'b0; x.jr_i = 1'b0; x.branch_taken_i = 1'b0; \
        x.mem_busy_i = 1'b0; x.clear_cnt_i = 1'b0; end

    // lw $8 in EX, ID instruction reads rs=$8
    `define LU8(x) begin \
        x.mem_read_IDEX_i = 1'b1; x.reg_rt_IDEX_i = 5'd8; \
        x.uses_rs_IFID_i = 1'b1; x.reg_rs_IFID_i = 5'd8; \
        x.uses_rt_IFID_i = 1'b1; x.reg_rt_IFID_i = 5'd3; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        `IDLE(ia)
        `IDLE(ib)
        `IDLE(ic)
        #1;
        chk("rst_pc_write", ia.PC_write_o, 1);
        chk("rst_ifid_write", ia.IFID_write_o, 1);
        chk("rst_idex_write", ia.IDEX_write_o, 1);
        chk("rst_ctl_flush", ia.ctl_flush_o, 1);
        chk("rst_ifid_flush", ia.IFID_flush_o, 1);
        chk("rst_idex_flush", ia.IDEX_flush_o, 1);
        chk("rst_mem_cpy", ia.mem_cpy_o, 0);
        chk("rst_stall", ia.stall_o, 0);
        chk("rst_stall_cnt", ia.stall_cnt_o, 0);
        chk("rst_flush_cnt", ia.flush_cnt_o, 0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        $display("reset released, idle outputs checked");

        // single-bubble load-use
        `LU8(ia)
        #1;
        chk("t1_pc_write", ia.PC_write_o, 0);
        chk("t1_ifid_write", ia.IFID_write_o, 0);
        chk("t1_ctl_flush", ia.ctl_flush_o, 0);
        chk("t1_idex_write", ia.IDEX_write_o, 1);
        chk("t1_stall", ia.stall_o, 1);
        cyc();
        chk("t1_stall_cnt", ia.stall_cnt_o, 1);
        `IDLE(ia)
        #1;
        chk("t1_pc_write_after", ia.PC_write_o, 1);
        chk("t1_ctl_flush_after", ia.ctl_flush_o, 1);
        $display("t1 single-bubble load-use done");

        // lw $9 -> sw rt=$9 rs=$4: copy, no stall
        ia.mem_read_IDEX_i = 1'b1; ia.reg_rt_IDEX_i = 5'd9;
        ia.mem_write_IFID_i = 1'b1;
        ia.uses_rs_IFID_i = 1'b1; ia.reg_rs_IFID_i = 5'd4;
        ia.uses_rt_IFID_i = 1'b1; ia.reg_rt_IFID_i = 5'd9;
        #1;
        chk("t3_cpy_mem_cpy", ia.mem_cpy_o, 1);
        chk("t3_cpy_stall", ia.stall_o, 0);
        chk("t3_cpy_pc_write", ia.PC_write_o, 1);
        ia.reg_rs_IFID_i = 5'd9;
        #1;
        chk("t3_rs_stall", ia.stall_o, 1);
        chk("t3_rs_mem_cpy", ia.mem_cpy_o, 0);
        cyc();
        chk("t3_stall_cnt", ia.stall_cnt_o, 2);
        `IDLE(ia)
        $display("t3 store-data copy vs store-address stall done");

        // $zero destination and unused rt never hazard
        ia.mem_read_IDEX_i = 1'b1; ia.reg_rt_IDEX_i = 5'd0;
        ia.uses_rs_IFID_i = 1'b1; ia.reg_rs_IFID_i = 5'd0;
        ia.uses_rt_IFID_i = 1'b1; ia.reg_rt_IFID_i = 5'd0;
        #1;
        chk("t4_zero_stall", ia.stall_o, 0);
        ia.reg_rt_IDEX_i = 5'd5; ia.reg_rs_IFID_i = 5'd1;
        ia.uses_rt_IFID_i = 1'b0; ia.reg_rt_IFID_i = 5'd5;
        #1;
        chk("t4_unused_rt_stall", ia.stall_o, 0);
        `IDLE(ia)
        $display("t4 operand qualification done");

        // control transfers
        ia.jr_i = 1'b1;
        #1;
        chk("t5_jr_ifid_flush", ia.IFID_flush_o, 0);
        chk("t5_jr_idex_flush", ia.IDEX_flush_o, 0);
        chk("t5_jr_pc_write", ia.PC_write_o, 1);
        cyc();
        chk("t5_flush_cnt1", ia.flush_cnt_o, 1);
        ia.jr_i = 1'b0; ia.branch_taken_i = 1'b0;
        #1;
        chk("t5_nt_ifid_flush", ia.IFID_flush_o, 1);
        chk("t5_nt_idex_flush", ia.IDEX_flush_o, 1);
        ia.branch_taken_i = 1'b1;
        #1;
        chk("t5_bt_ifid_flush", ia.IFID_flush_o, 0);
        chk("t5_bt_idex_flush", ia.IDEX_flush_o, 1);
        cyc();
        chk("t5_flush_cnt2", ia.flush_cnt_o, 2);
        ia.branch_taken_i = 1'b0; ia.jr_i = 1'b1;
        `LU8(ia)
        #1;
        chk("t5_jrlu_stall", ia.stall_o, 1);
        chk("t5_jrlu_ifid_flush", ia.IFID_flush_o, 1);
        chk("t5_jrlu_idex_flush", ia.IDEX_flush_o, 1);
        chk("t5_jrlu_ctl_flush", ia.ctl_flush_o, 0);
        cyc();
        chk("t5_jrlu_stall_cnt", ia.stall_cnt_o, 3);
        chk("t5_jrlu_flush_cnt", ia.flush_cnt_o, 2);
        `IDLE(ia)
        ia.jmp_i = 1'b1; ia.branch_taken_i = 1'b1;
        #1;
        chk("t5_union_ifid_flush", ia.IFID_flush_o, 0);
        chk("t5_union_idex_flush", ia.IDEX_flush_o, 0);
        ia.mem_busy_i = 1'b1;
        #1;
        chk("t5_frz_pc_write", ia.PC_write_o, 0);
        chk("t5_frz_idex_write", ia.IDEX_write_o, 0);
        chk("t5_frz_ifid_flush", ia.IFID_flush_o, 1);
        chk("t5_frz_idex_flush", ia.IDEX_flush_o, 1);
        cyc();
        chk("t5_frz_flush_cnt", ia.flush_cnt_o, 2);
        `IDLE(ia)
        `LU8(ia)
        ia.clear_cnt_i = 1'b1;
        cyc();
        chk("t5_clr_stall_cnt", ia.stall_cnt_o, 0);
        chk("t5_clr_flush_cnt", ia.flush_cnt_o, 0);
        `IDLE(ia)
        $display("t5 control transfer, freeze and clear done");

        // 3-cycle load-use with a 2-cycle freeze in the middle
        `LU8(ib)
        #1;
        chk("t2_c1_stall", ib.stall_o, 1);
        chk("t2_c1_pc_write", ib.PC_write_o, 0);
        cyc();
        `IDLE(ib)
        #1;
        chk("t2_c2_stall", ib.stall_o, 1);
        ib.mem_busy_i = 1'b1;
        #1;
        chk("t2_frz_stall", ib.stall_o, 0);
        chk("t2_frz_pc_write", ib.PC_write_o, 0);
        chk("t2_frz_idex_write", ib.IDEX_write_o, 0);
        chk("t2_frz_ctl_flush", ib.ctl_flush_o, 1);
        cyc();
        cyc();
        chk("t2_frz_stall_cnt", ib.stall_cnt_o, 1);
        ib.mem_busy_i = 1'b0;
        #1;
        chk("t2_c2b_stall", ib.stall_o, 1);
        chk("t2_c2b_pc_write", ib.PC_write_o, 0);
        cyc();
        #1;
        chk("t2_c3_stall", ib.stall_o, 1);
        cyc();
        #1;
        chk("t2_end_stall", ib.stall_o, 0);
        chk("t2_end_pc_write", ib.PC_write_o, 1);
        chk("t2_stall_cnt", ib.stall_cnt_o, 3);
        $display("t2 three-cycle stall across freeze done");

        // 2-bit counter saturation, clear, reset mid-stall
        `LU8(ic)
        for (int i = 0; i < 5; i++) cyc();
        chk("t6_sat_stall_cnt", ic.stall_cnt_o, 3);
        `IDLE(ic)
        ic.clear_cnt_i = 1'b1;
        cyc();
        chk("t6_clr_stall_cnt", ic.stall_cnt_o, 0);
        ic.clear_cnt_i = 1'b0;
        #1;
        chk("t6_run_stall", ic.stall_o, 0);
        `LU8(ic)
        cyc();
        `IDLE(ic)
        #1;
        chk("t6_lu_stall", ic.stall_o, 1);
        chk("t6_lu_stall_cnt", ic.stall_cnt_o, 1);
        reset = 1'b0;
        #1;
        chk("t6_arst_stall", ic.stall_o, 0);
        chk("t6_arst_pc_write", ic.PC_write_o, 1);
        chk("t6_arst_ctl_flush", ic.ctl_flush_o, 1);
        chk("t6_arst_stall_cnt", ic.stall_cnt_o, 0);
        cyc();
        reset = 1'b1;
        cyc();
        #1;
        chk("t6_post_stall", ic.stall_o, 0);
        chk("t6_post_ifid_write", ic.IFID_write_o, 1);
        $display("t6 saturation, clear and async reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
